// File: rtl/bus_gpio_timer_if.sv
// Ibex-style data-bus bundle (req/gnt/rvalid) shared by the load/store initiator and its responders.
interface bus_gpio_timer_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/bus_gpio_timer.sv
// GPIO out/in registers plus optional mtime/mtimecmp timer (BUS_GPIO_TIMER_TIMER_EN) on the data bus.
// Grant after WaitStates cycles of held req; response registered one cycle after grant.
module bus_gpio_timer #(
  parameter logic [31:0] BaseAddr   = 32'h0001_0000,
  parameter int          GpoWidth   = 13,
  parameter int          GpiWidth   = 1,
  parameter int          WaitStates = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  bus_gpio_timer_if.slave     bus,
  input  logic [GpiWidth-1:0] gpi_i,
  output logic [GpoWidth-1:0] gpo_o,
  output logic                irq_o
);
  localparam logic [9:0] OffOut = 10'd0, OffIn = 10'd1, OffMtime = 10'd2,
                         OffMtcmp = 10'd3, OffCtrl = 10'd4;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic                w_sel, w_gnt, w_wr, w_err;
  logic [9:0]          w_off;
  logic [31:0]         w_rdata, w_gpo_ext, w_gpi_ext, w_gpo_wr;
  logic [31:0]         w_mtime_rd, w_mtcmp_rd, w_ctrl_rd;
  logic                r_rvalid, r_err;
  logic [31:0]         r_rdata;
  logic [GpoWidth-1:0] r_gpo;
  logic [GpiWidth-1:0] r_gpi_s1, r_gpi_s2;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign w_sel = (bus.addr_i[31:12] == BaseAddr[31:12]);
  assign w_off = bus.addr_i[11:2];
  assign w_wr  = w_gnt & bus.we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A request dropped while waiting is a protocol violation: abandon it silently.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_i && w_sel) begin
          if (WaitStates == 0) begin
            w_gnt = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 3'(WaitStates - 1);
          end
        end
      end
      WAIT: begin
        if (!bus.req_i) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == 3'd0) begin
          w_gnt       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst_i) w_gnt = 1'b0;
  end

  always_comb begin
    w_gpo_ext                 = '0;
    w_gpo_ext[GpoWidth-1:0]   = r_gpo;
    w_gpi_ext                 = '0;
    w_gpi_ext[GpiWidth-1:0]   = r_gpi_s2;
  end

  assign w_gpo_wr = be_merge(w_gpo_ext, bus.wdata_i, bus.be_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gpo    <= '0;
      r_gpi_s1 <= '0;
      r_gpi_s2 <= '0;
    end else begin
      r_gpi_s1 <= gpi_i;
      r_gpi_s2 <= r_gpi_s1;
      if (w_wr && (w_off == OffOut)) r_gpo <= w_gpo_wr[GpoWidth-1:0];
    end
  end

`ifdef BUS_GPIO_TIMER_TIMER_EN
  logic [31:0] r_mtime, r_mtimecmp;
  logic        r_en, r_irq;

  // A granted MTIME write takes precedence over the increment in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime    <= 32'd0;
      r_mtimecmp <= 32'hFFFF_FFFF;
      r_en       <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_off == OffMtime)) r_mtime <= be_merge(r_mtime, bus.wdata_i, bus.be_i);
      else if (r_en)                  r_mtime <= r_mtime + 32'd1;
      if (w_wr && (w_off == OffMtcmp)) r_mtimecmp <= be_merge(r_mtimecmp, bus.wdata_i, bus.be_i);
      if (w_wr && (w_off == OffCtrl) && bus.be_i[0]) r_en <= bus.wdata_i[0];
      r_irq <= r_en && (r_mtime >= r_mtimecmp);
    end
  end

  assign w_mtime_rd = r_mtime;
  assign w_mtcmp_rd = r_mtimecmp;
  assign w_ctrl_rd  = {31'd0, r_en};
  assign irq_o      = r_irq;
`else
  assign w_mtime_rd = 32'd0;
  assign w_mtcmp_rd = 32'd0;
  assign w_ctrl_rd  = 32'd0;
  assign irq_o      = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_off)
      OffOut:   w_rdata = w_gpo_ext;
      OffIn:    w_rdata = w_gpi_ext;
      OffMtime: w_rdata = w_mtime_rd;
      OffMtcmp: w_rdata = w_mtcmp_rd;
      OffCtrl:  w_rdata = w_ctrl_rd;
      default:  w_err   = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_rdata  <= w_gnt ? w_rdata : 32'd0;
      r_err    <= w_gnt & w_err;
    end
  end

  // Masking with rst_i drops a response that is already registered when reset arrives.
  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid & ~rst_i;
  assign bus.rdata_o  = rst_i ? 32'd0 : r_rdata;
  assign bus.err_o    = r_err & ~rst_i;
  assign gpo_o        = r_gpo;
endmodule

// File: tb/tb_bus_gpio_timer.sv
// Directed bench: dut0 with zero wait states for the register map, dut1 with two wait states.
module tb_bus_gpio_timer;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  gpi0, gpi1;
  logic [12:0] gpo0, gpo1;
  logic        irq0, irq1;
  int          n_checks = 0;
  int          n_pass   = 0;

  bus_gpio_timer_if bif0 ();
  bus_gpio_timer_if bif1 ();

  bus_gpio_timer #(.WaitStates(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bif0.slave), .gpi_i(gpi0), .gpo_o(gpo0), .irq_o(irq0)
  );
  bus_gpio_timer #(.WaitStates(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bif1.slave), .gpi_i(gpi1), .gpo_o(gpo1), .irq_o(irq1)
  );

  always #5 clk = ~clk;

  // Starts and ends at negedge+1; returns cycles until grant (8 = never granted).
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output logic rv, output int gcyc);
    bif0.req_i = 1'b1; bif0.we_i = we; bif0.addr_i = addr; bif0.be_i = be; bif0.wdata_i = wd;
    gcyc = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      gcyc++;
      if (bif0.gnt_o === 1'b1) break;
      @(negedge clk); #1;
    end
    @(posedge clk); @(negedge clk); #1;
    rv = bif0.rvalid_o; rd = bif0.rdata_o; er = bif0.err_o;
    bif0.req_i = 1'b0; bif0.we_i = 1'b0;
  endtask

  task automatic test_reset();
    bif0.req_i = 1'b1; bif0.addr_i = BASE; bif0.we_i = 1'b0;
    bif1.req_i = 1'b1; bif1.addr_i = BASE;
    #1;
    n_checks++; if (bif0.gnt_o !== 1'b0) $display("FAIL rst_gnt0 got %b want 0", bif0.gnt_o); else n_pass++;
    n_checks++; if (bif1.gnt_o !== 1'b0) $display("FAIL rst_gnt1 got %b want 0", bif1.gnt_o); else n_pass++;
    n_checks++; if (bif0.rvalid_o !== 1'b0) $display("FAIL rst_rvalid got %b want 0", bif0.rvalid_o); else n_pass++;
    n_checks++; if (bif0.rdata_o !== 32'd0 || bif0.err_o !== 1'b0)
      $display("FAIL rst_rdata got %h/%b want 0/0", bif0.rdata_o, bif0.err_o); else n_pass++;
    n_checks++; if (gpo0 !== 13'd0 || irq0 !== 1'b0)
      $display("FAIL rst_outs gpo %h irq %b want 0/0", gpo0, irq0); else n_pass++;
    bif0.req_i = 1'b0; bif1.req_i = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_gpio_out();
    logic [31:0] rd; logic er, rv; int g;
    xfer(1'b1, BASE, 4'b0011, 32'h0000_1ABC, rd, er, rv, g);
    n_checks++; if (g !== 1 || rv !== 1'b1) $display("FAIL out_wr_lat gnt %0d rv %b want 1/1", g, rv); else n_pass++;
    n_checks++; if (gpo0 !== 13'h1ABC) $display("FAIL out_gpo got %h want 1abc", gpo0); else n_pass++;
    xfer(1'b0, BASE, 4'b1111, 32'd0, rd, er, rv, g);
    n_checks++; if (rv !== 1'b1 || g !== 1) $display("FAIL out_rd_lat rv %b gnt %0d want 1/1", rv, g); else n_pass++;
    n_checks++; if (rd !== 32'h0000_1ABC || er !== 1'b0)
      $display("FAIL out_rd got %h/%b want 00001abc/0", rd, er); else n_pass++;
    xfer(1'b1, BASE, 4'b0001, 32'hFFFF_FF55, rd, er, rv, g);
    n_checks++; if (gpo0 !== 13'h1A55) $display("FAIL out_be0 got %h want 1a55", gpo0); else n_pass++;
    xfer(1'b1, BASE, 4'b1111, 32'hFFFF_FFFF, rd, er, rv, g);
    xfer(1'b0, BASE, 4'b1111, 32'd0, rd, er, rv, g);
    n_checks++; if (rd !== 32'h0000_1FFF) $display("FAIL out_upper got %h want 00001fff", rd); else n_pass++;
  endtask

  task automatic test_gpio_in();
    logic [31:0] r1, r2, r3, rd; logic er, rv; int g;
    gpi0 = 1'b1;
    xfer(1'b0, BASE + 32'h4, 4'hF, 32'd0, r1, er, rv, g);
    xfer(1'b0, BASE + 32'h4, 4'hF, 32'd0, r2, er, rv, g);
    xfer(1'b0, BASE + 32'h4, 4'hF, 32'd0, r3, er, rv, g);
    n_checks++; if (r1 !== 32'd0 || r2 !== 32'd0) $display("FAIL in_sync_early got %h %h want 0 0", r1, r2); else n_pass++;
    n_checks++; if (r3 !== 32'd1) $display("FAIL in_sync got %h want 1", r3); else n_pass++;
    xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, rd, er, rv, g);
    n_checks++; if (er !== 1'b0 || rv !== 1'b1) $display("FAIL in_write err %b rv %b want 0/1", er, rv); else n_pass++;
  endtask

  task automatic test_bad_offset();
    logic [31:0] rd; logic er, rv; int g;
    xfer(1'b0, BASE + 32'h40, 4'hF, 32'd0, rd, er, rv, g);
    n_checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'd0)
      $display("FAIL bad_rd rv %b err %b data %h want 1/1/0", rv, er, rd); else n_pass++;
    xfer(1'b1, BASE + 32'h40, 4'hF, 32'd0, rd, er, rv, g);
    n_checks++; if (er !== 1'b1) $display("FAIL bad_wr_err got %b want 1", er); else n_pass++;
    n_checks++; if (gpo0 !== 13'h1FFF) $display("FAIL bad_wr_side got %h want 1fff", gpo0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] ed [3];
    logic        ee [3];
    a[0] = BASE;          ed[0] = 32'h1FFF; ee[0] = 1'b0;
    a[1] = BASE + 32'h4;  ed[1] = 32'd1;    ee[1] = 1'b0;
    a[2] = BASE + 32'h40; ed[2] = 32'd0;    ee[2] = 1'b1;
    bif0.req_i = 1'b1; bif0.we_i = 1'b0; bif0.be_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bif0.addr_i = a[i]; else bif0.req_i = 1'b0;
      #1;
      if (i < 3) begin
        n_checks++; if (bif0.gnt_o !== 1'b1) $display("FAIL b2b_gnt%0d got %b want 1", i, bif0.gnt_o); else n_pass++;
      end
      if (i > 0) begin
        n_checks++;
        if (bif0.rvalid_o !== 1'b1 || bif0.rdata_o !== ed[i-1] || bif0.err_o !== ee[i-1])
          $display("FAIL b2b_rsp%0d got %b/%h/%b want 1/%h/%b", i-1, bif0.rvalid_o,
                   bif0.rdata_o, bif0.err_o, ed[i-1], ee[i-1]);
        else n_pass++;
      end
      @(negedge clk); #1;
    end
    n_checks++; if (bif0.rvalid_o !== 1'b0) $display("FAIL b2b_idle got %b want 0", bif0.rvalid_o); else n_pass++;
  endtask

  task automatic test_wait_states();
    int first;
    bif1.req_i = 1'b1; bif1.addr_i = BASE + 32'h4; bif1.we_i = 1'b0; bif1.be_i = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_checks++;
      if (bif1.gnt_o !== (c == 3) || bif1.rvalid_o !== 1'b0)
        $display("FAIL ws_cyc%0d gnt %b rv %b want %b/0", c, bif1.gnt_o, bif1.rvalid_o, (c == 3));
      else n_pass++;
      @(negedge clk); #1;
    end
    bif1.req_i = 1'b0;
    n_checks++; if (bif1.rvalid_o !== 1'b1 || bif1.rdata_o !== 32'd1 || bif1.err_o !== 1'b0)
      $display("FAIL ws_rsp got %b/%h/%b want 1/00000001/0", bif1.rvalid_o, bif1.rdata_o, bif1.err_o);
    else n_pass++;
    // Withdraw a request while it waits: nothing may be granted or answered.
    @(negedge clk); #1;
    bif1.req_i = 1'b1;
    @(negedge clk); #1;
    bif1.req_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (bif1.gnt_o !== 1'b0 || bif1.rvalid_o !== 1'b0)
        $display("FAIL ws_abort%0d gnt %b rv %b want 0/0", c, bif1.gnt_o, bif1.rvalid_o); else n_pass++;
      @(negedge clk); #1;
    end
    bif1.req_i = 1'b1;
    first = 0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (bif1.gnt_o === 1'b1) begin first = c; break; end
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    bif1.req_i = 1'b0;
    n_checks++; if (first !== 3) $display("FAIL ws_after_abort gnt cycle %0d want 3", first); else n_pass++;
    @(negedge clk); #1;
  endtask

`ifdef BUS_GPIO_TIMER_TIMER_EN
  task automatic test_timer();
    logic [31:0] rd; logic er, rv; int g, n;
    xfer(1'b1, BASE + 32'hC, 4'hF, 32'd10, rd, er, rv, g);
    xfer(1'b1, BASE + 32'h8, 4'hF, 32'd0, rd, er, rv, g);
    xfer(1'b1, BASE + 32'h10, 4'hF, 32'd1, rd, er, rv, g);
    n_checks++; if (irq0 !== 1'b0) $display("FAIL tmr_irq_start got %b want 0", irq0); else n_pass++;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk); #1;
      n = k;
      if (irq0 === 1'b1) break;
    end
    n_checks++; if (irq0 !== 1'b1 || n < 11 || n > 12)
      $display("FAIL tmr_irq_rise after %0d cycles irq %b want 11..12/1", n, irq0); else n_pass++;
    xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, rd, er, rv, g);
    n_checks++; if (rd !== 32'd1 || er !== 1'b0) $display("FAIL tmr_ctrl_rd got %h/%b want 1/0", rd, er); else n_pass++;
    xfer(1'b1, BASE + 32'hC, 4'hF, 32'hFFFF_FFFF, rd, er, rv, g);
    n_checks++; if (irq0 !== 1'b1) $display("FAIL tmr_irq_hold got %b want 1", irq0); else n_pass++;
    @(posedge clk); @(negedge clk); #1;
    n_checks++; if (irq0 !== 1'b0) $display("FAIL tmr_irq_fall got %b want 0", irq0); else n_pass++;
    xfer(1'b1, BASE + 32'h8, 4'hF, 32'hFFFF_FFFE, rd, er, rv, g);
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    xfer(1'b0, BASE + 32'h8, 4'hF, 32'd0, rd, er, rv, g);
    n_checks++; if (rd !== 32'd0) $display("FAIL tmr_wrap got %h want 0", rd); else n_pass++;
    xfer(1'b1, BASE + 32'h10, 4'hF, 32'd0, rd, er, rv, g);
  endtask
`else
  task automatic test_timer();
    logic [31:0] rd; logic er, rv; int g;
    xfer(1'b1, BASE + 32'h8, 4'hF, 32'd5, rd, er, rv, g);
    n_checks++; if (er !== 1'b0) $display("FAIL tmr_off_wr_err got %b want 0", er); else n_pass++;
    xfer(1'b0, BASE + 32'h8, 4'hF, 32'd0, rd, er, rv, g);
    n_checks++; if (rd !== 32'd0 || er !== 1'b0) $display("FAIL tmr_off_mtime got %h/%b want 0/0", rd, er); else n_pass++;
    xfer(1'b1, BASE + 32'h10, 4'hF, 32'd1, rd, er, rv, g);
    xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, rd, er, rv, g);
    n_checks++; if (rd !== 32'd0) $display("FAIL tmr_off_ctrl got %h want 0", rd); else n_pass++;
    xfer(1'b0, BASE + 32'hC, 4'hF, 32'd0, rd, er, rv, g);
    n_checks++; if (rd !== 32'd0 || irq0 !== 1'b0)
      $display("FAIL tmr_off_cmp got %h irq %b want 0/0", rd, irq0); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    bif0.req_i = 1'b1; bif0.addr_i = BASE; bif0.we_i = 1'b0; bif0.be_i = 4'hF;
    #1;
    n_checks++; if (bif0.gnt_o !== 1'b1) $display("FAIL rstmid_gnt got %b want 1", bif0.gnt_o); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1; bif0.req_i = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (bif0.rvalid_o !== 1'b0 || bif0.rdata_o !== 32'd0)
      $display("FAIL rstmid_drop rv %b data %h want 0/0", bif0.rvalid_o, bif0.rdata_o); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (gpo0 !== 13'd0 || irq0 !== 1'b0 || bif0.rvalid_o !== 1'b0 ||
                    bif0.rdata_o !== 32'd0 || bif0.err_o !== 1'b0)
      $display("FAIL rstmid_outs gpo %h irq %b rv %b data %h err %b want all 0",
               gpo0, irq0, bif0.rvalid_o, bif0.rdata_o, bif0.err_o);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    gpi0 = 1'b0; gpi1 = 1'b1;
    bif0.req_i = 1'b0; bif0.addr_i = '0; bif0.we_i = 1'b0; bif0.be_i = 4'h0; bif0.wdata_i = '0;
    bif1.req_i = 1'b0; bif1.addr_i = '0; bif1.we_i = 1'b0; bif1.be_i = 4'h0; bif1.wdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    test_reset();
    test_gpio_out();
    test_gpio_in();
    test_bad_offset();
    test_back_to_back();
    test_wait_states();
    test_timer();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
